mem_lsu: RTL and testbench
==========================

// Module: mem_lsu
// PURPOSE
//  MEM-stage load/store unit. Sits directly after the EX->MEM pipeline register.
//  Consumes its MEM_* bundle and drives the data bus for loads and stores.
//  Aligns and extends load data. Raises misalign and bus-error flags.
//  Presents one registered result entry to WB over a valid/ready handshake.
// PARAMETERS
//  XLEN  32  datapath width; only 32 is supported (4 byte lanes)
// PORTS
//  clk              in   1     clock, rising edge
//  rst              in   1     synchronous, active-high reset
//  MEM_valid_i      in   1     upstream entry valid
//  lsu_ready_o      out  1     upstream may advance; drives MEM's WB_ready_i
//  MEM_pc_i         in   32    pc, passed through
//  MEM_ld_st_info_i in   5     {is_load,is_store,is_unsigned,size[1:0]}; size 0=B 1=H 2=W
//  MEM_rd_wen_i     in   1     rd write enable
//  MEM_rd_idx_i     in   5     rd index
//  MEM_alu_res_i    in   32    effective address (ld/st) or result (others)
//  MEM_rs2_rdata_i  in   32    store data
//  dbus_req_o       out  1     bus request, held until dbus_gnt_i
//  dbus_we_o        out  1     1 = store
//  dbus_addr_o      out  32    word-aligned address: {addr[31:2],2'b00}
//  dbus_be_o        out  4     byte enables
//  dbus_wdata_o     out  32    lane-replicated store data
//  dbus_gnt_i       in   1     request accepted
//  dbus_rvalid_i    in   1     response valid (loads and stores)
//  dbus_rdata_i     in   32    load word
//  dbus_err_i       in   1     response error, qualified by dbus_rvalid_i
//  WB_ready_i       in   1     WB accepts the entry
//  LSU_valid_o      out  1     result entry valid
//  LSU_pc_o         out  32    pc
//  LSU_rd_wen_o     out  1     rd write enable (0 on any LSU exception)
//  LSU_rd_idx_o     out  5     rd index
//  LSU_rd_wdata_o   out  32    extended load data, else MEM_alu_res_i
//  LSU_ld_misalign_o out 1     load address misaligned
//  LSU_st_misalign_o out 1     store address misaligned
//  LSU_bus_err_o    out  1     dbus_err_i seen on this access
// BEHAVIOUR
//  - Reset: FSM=IDLE. Every output is 0. All LSU_* outputs are ANDed with LSU_valid_o.
//  - FSM states and transitions:
//    - IDLE: lsu_ready_o=1; LSU_valid_o=0.
//    - RESP: LSU_valid_o=1; lsu_ready_o=WB_ready_i.
//    - Accept = MEM_valid_i && lsu_ready_o. On accept, capture the input bundle.
//    - Accepted aligned ld/st -> REQ. Any other accepted entry -> RESP; LSU_valid_o=1 next cycle.
//    - REQ: dbus_req_o=1 with addr/we/be/wdata stable. dbus_gnt_i -> WAIT.
//    - WAIT: dbus_rvalid_i -> RESP. Load data, or the error flag, is registered.
//    - RESP with WB_ready_i: accept a new entry (routed as above), or go to IDLE if none.
//    - Throughput: non-memory ops 1/cycle back-to-back.
//    - Memory latency: accept -> LSU_valid_o is >= 3 cycles with gnt and rvalid each at first opportunity.
//  - Misalign rules: H with addr[0]=1; W with addr[1:0]!=0.
//    - No bus request; go straight to RESP.
//    - Set ld_misalign or st_misalign; LSU_rd_wen_o=0.
//  - Byte enables and store data:
//    - B: be=4'b0001<<addr[1:0]; wdata={4{rs2[7:0]}}.
//    - H: be=4'b0011<<addr[1:0]; wdata={2{rs2[15:0]}}.
//    - W: be=4'b1111.
//    - Loads drive the same be.
//  - Load data: (rdata >> 8*addr[1:0]) truncated to size. Zero-extend if is_unsigned, else sign-extend.
//  - Bus error: LSU_bus_err_o=1; LSU_rd_wen_o=0; rd_wdata=0.
//  - gnt and rvalid in the same cycle are not allowed; rvalid arrives >=1 cycle after gnt.
//  - dbus_rvalid_i outside WAIT is ignored.
//  - Reset mid-access (REQ/WAIT): IDLE next cycle, req dropped. A late rvalid is ignored.
//  - While REQ/WAIT: lsu_ready_o=0; input bundle changes are ignored.
// STRUCTURE
//  - defines.v: LD_ST info field indices and width (5); size codes; FSM state localparams (2-bit).
//  - Sub-module lsu_align (combinational): be/wdata generation, load extract/extend, misalign detect.
//  - mem_lsu holds the FSM, capture registers and output register.
// TESTING
//  1. ALU op rd=5 res=0x1234 for 3 consecutive cycles, WB_ready=1
//     -> three LSU_valid beats, rd_wdata=0x1234, no stalls.
//  2. LB addr=0x1003, rdata=0x80FFFFFF, gnt/rvalid at first chance
//     -> be=1000, rd_wdata=0xFFFFFF80; LBU -> 0x00000080.
//  3. SH addr=0x2002 rs2=0xABCD1234
//     -> dbus_addr=0x2000, be=1100, wdata=0x12341234, we=1, rd_wen=0.
//  4. LW addr=0x3001 -> dbus_req never asserted; ld_misalign=1, rd_wen=0, valid next cycle.
//  5. LW with gnt delayed 3 cycles, rvalid+err
//     -> req held 4 cycles with addr stable; bus_err=1, rd_wen=0.
//  6. WB_ready=0 for 5 cycles in RESP -> outputs stable, lsu_ready_o=0.
//     rst asserted in WAIT -> IDLE, req=0; later rvalid produces no beat.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg
//   Shared types for the MEM-stage load/store unit: the packed ld/st info
//   bundle, access-size codes and the LSU FSM state encoding.
package mem_lsu_pkg;

   localparam int LS_INFO_W = 5;

   typedef enum logic [1:0] {
      SIZE_B = 2'd0,
      SIZE_H = 2'd1,
      SIZE_W = 2'd2
   } ls_size_e;

   // Field order matches MEM_ld_st_info_i: {is_load,is_store,is_unsigned,size}
   typedef struct packed {
      logic     is_load;
      logic     is_store;
      logic     is_unsigned;
      ls_size_e size;
   } ls_info_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } lsu_state_e;

endpackage

// File: rtl/mem_lsu_align.sv
// mem_lsu_align
//   Combinational lane logic for a 32-bit data bus.
//   size_i, is_unsigned_i, addr_lo_i : access descriptor (addr_lo_i = addr[1:0])
//   st_data_i  -> be_o, wdata_o      : byte enables and lane-replicated store data
//   ld_word_i  -> ld_data_o          : load lane extracted and sign/zero extended
//   misalign_o                       : H on odd address, W on non-word address
module mem_lsu_align
   import mem_lsu_pkg::*;
(
   input  ls_size_e    size_i,
   input  logic        is_unsigned_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] st_data_i,
   input  logic [31:0] ld_word_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] ld_data_o,
   output logic        misalign_o
);

   logic [31:0] ld_shifted;
   logic        sext;

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      be_o       = 4'b1111;
      wdata_o    = st_data_i;
      misalign_o = 1'b0;
      ld_shifted = ld_word_i >> {addr_lo_i, 3'b000};
      sext       = ~is_unsigned_i;
      ld_data_o  = ld_shifted;
      case (size_i)
         SIZE_B: begin
            be_o      = 4'b0001 << addr_lo_i;
            wdata_o   = {4{st_data_i[7:0]}};
            ld_data_o = {{24{sext & ld_shifted[7]}}, ld_shifted[7:0]};
         end
         SIZE_H: begin
            be_o       = 4'b0011 << addr_lo_i;
            wdata_o    = {2{st_data_i[15:0]}};
            ld_data_o  = {{16{sext & ld_shifted[15]}}, ld_shifted[15:0]};
            misalign_o = addr_lo_i[0];
         end
         default: misalign_o = |addr_lo_i;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu
//   MEM-stage load/store unit. Accepts one MEM_* entry at a time, performs the
//   data-bus access for aligned loads/stores, and presents a registered result
//   entry to WB over LSU_valid_o / WB_ready_i.
//   Upstream : MEM_valid_i, lsu_ready_o, MEM_pc_i, MEM_ld_st_info_i,
//              MEM_rd_wen_i, MEM_rd_idx_i, MEM_alu_res_i, MEM_rs2_rdata_i
//   Data bus : dbus_req_o/we/addr/be/wdata, dbus_gnt_i, dbus_rvalid_i,
//              dbus_rdata_i, dbus_err_i
//   WB       : WB_ready_i, LSU_valid_o, LSU_pc_o, LSU_rd_wen_o, LSU_rd_idx_o,
//              LSU_rd_wdata_o, LSU_ld_misalign_o, LSU_st_misalign_o, LSU_bus_err_o
//   Only XLEN = 32 is supported.
module mem_lsu
   import mem_lsu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 MEM_valid_i,
   output logic                 lsu_ready_o,
   input  logic [XLEN-1:0]      MEM_pc_i,
   input  logic [LS_INFO_W-1:0] MEM_ld_st_info_i,
   input  logic                 MEM_rd_wen_i,
   input  logic [4:0]           MEM_rd_idx_i,
   input  logic [XLEN-1:0]      MEM_alu_res_i,
   input  logic [XLEN-1:0]      MEM_rs2_rdata_i,
   output logic                 dbus_req_o,
   output logic                 dbus_we_o,
   output logic [XLEN-1:0]      dbus_addr_o,
   output logic [3:0]           dbus_be_o,
   output logic [XLEN-1:0]      dbus_wdata_o,
   input  logic                 dbus_gnt_i,
   input  logic                 dbus_rvalid_i,
   input  logic [XLEN-1:0]      dbus_rdata_i,
   input  logic                 dbus_err_i,
   input  logic                 WB_ready_i,
   output logic                 LSU_valid_o,
   output logic [XLEN-1:0]      LSU_pc_o,
   output logic                 LSU_rd_wen_o,
   output logic [4:0]           LSU_rd_idx_o,
   output logic [XLEN-1:0]      LSU_rd_wdata_o,
   output logic                 LSU_ld_misalign_o,
   output logic                 LSU_st_misalign_o,
   output logic                 LSU_bus_err_o
);

   lsu_state_e      state_q, state_d;
   ls_info_t        info_q, info_d;
   logic [XLEN-1:0] pc_q, pc_d, addr_q, addr_d, rs2_q, rs2_d, wdata_q, wdata_d;
   logic [4:0]      rd_idx_q, rd_idx_d;
   logic            rd_wen_q, rd_wen_d, ld_mis_q, ld_mis_d;
   logic            st_mis_q, st_mis_d, bus_err_q, bus_err_d;

   ls_info_t        info_in, al_info;
   logic [1:0]      al_addr_lo;
   logic [3:0]      al_be;
   logic [31:0]     al_wdata, al_ld_data;
   logic            al_misalign, busy, accept, mem_op, mis, req, valid;

   // The align block serves the incoming entry while accepting (misalign
   // routing) and the captured entry while the bus access is in flight.
   assign info_in    = ls_info_t'(MEM_ld_st_info_i);
   assign busy       = (state_q == ST_REQ) || (state_q == ST_WAIT);
   assign al_info    = busy ? info_q : info_in;
   assign al_addr_lo = busy ? addr_q[1:0] : MEM_alu_res_i[1:0];

   mem_lsu_align u_align (
      .size_i        (al_info.size),
      .is_unsigned_i (al_info.is_unsigned),
      .addr_lo_i     (al_addr_lo),
      .st_data_i     (rs2_q),
      .ld_word_i     (dbus_rdata_i),
      .be_o          (al_be),
      .wdata_o       (al_wdata),
      .ld_data_o     (al_ld_data),
      .misalign_o    (al_misalign)
   );

   // Ready is held low during reset so nothing is accepted while it is applied.
   assign lsu_ready_o = ~rst & ((state_q == ST_IDLE) || ((state_q == ST_RESP) && WB_ready_i));
   assign accept      = MEM_valid_i & lsu_ready_o;
   assign mem_op      = info_in.is_load | info_in.is_store;
   assign mis         = mem_op & al_misalign;

   always_comb begin
      state_d   = state_q;
      info_d    = info_q;
      pc_d      = pc_q;
      addr_d    = addr_q;
      rs2_d     = rs2_q;
      wdata_d   = wdata_q;
      rd_idx_d  = rd_idx_q;
      rd_wen_d  = rd_wen_q;
      ld_mis_d  = ld_mis_q;
      st_mis_d  = st_mis_q;
      bus_err_d = bus_err_q;

      case (state_q)
         ST_REQ:  if (dbus_gnt_i) state_d = ST_WAIT;
         ST_WAIT: begin
            if (dbus_rvalid_i) begin
               state_d = ST_RESP;
               if (dbus_err_i) begin
                  bus_err_d = 1'b1;
                  rd_wen_d  = 1'b0;
                  wdata_d   = '0;
               end else if (info_q.is_load) begin
                  wdata_d = al_ld_data;
               end
            end
         end
         ST_RESP: if (WB_ready_i) state_d = ST_IDLE;
         default: ;
      endcase

      // A new entry overrides RESP->IDLE so non-memory ops stream 1/cycle.
      if (accept) begin
         info_d    = info_in;
         pc_d      = MEM_pc_i;
         addr_d    = MEM_alu_res_i;
         rs2_d     = MEM_rs2_rdata_i;
         wdata_d   = MEM_alu_res_i;
         rd_idx_d  = MEM_rd_idx_i;
         rd_wen_d  = MEM_rd_wen_i & ~mis;
         ld_mis_d  = mis & info_in.is_load;
         st_mis_d  = mis & ~info_in.is_load;
         bus_err_d = 1'b0;
         state_d   = (mem_op && !mis) ? ST_REQ : ST_RESP;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         info_q    <= '0;
         pc_q      <= '0;
         addr_q    <= '0;
         rs2_q     <= '0;
         wdata_q   <= '0;
         rd_idx_q  <= '0;
         rd_wen_q  <= 1'b0;
         ld_mis_q  <= 1'b0;
         st_mis_q  <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         info_q    <= info_d;
         pc_q      <= pc_d;
         addr_q    <= addr_d;
         rs2_q     <= rs2_d;
         wdata_q   <= wdata_d;
         rd_idx_q  <= rd_idx_d;
         rd_wen_q  <= rd_wen_d;
         ld_mis_q  <= ld_mis_d;
         st_mis_q  <= st_mis_d;
         bus_err_q <= bus_err_d;
      end
   end

   assign req          = (state_q == ST_REQ);
   assign dbus_req_o   = req;
   assign dbus_we_o    = req & info_q.is_store & ~info_q.is_load;
   assign dbus_addr_o  = {addr_q[XLEN-1:2], 2'b00} & {XLEN{req}};
   assign dbus_be_o    = al_be & {4{req}};
   assign dbus_wdata_o = al_wdata & {XLEN{req}};

   assign valid             = (state_q == ST_RESP);
   assign LSU_valid_o       = valid;
   assign LSU_pc_o          = pc_q & {XLEN{valid}};
   assign LSU_rd_wen_o      = rd_wen_q & valid;
   assign LSU_rd_idx_o      = rd_idx_q & {5{valid}};
   assign LSU_rd_wdata_o    = wdata_q & {XLEN{valid}};
   assign LSU_ld_misalign_o = ld_mis_q & valid;
   assign LSU_st_misalign_o = st_mis_q & valid;
   assign LSU_bus_err_o     = bus_err_q & valid;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu
//   Self-checking bench for mem_lsu. Expected WB entries are queued as
//   stimulus is driven; a monitor pops and compares on every WB handshake.
//   Scenario tasks add their own inline checks on bus and handshake signals.
module tb_mem_lsu;

   typedef struct packed {
      logic [31:0] pc;
      logic        rd_wen;
      logic [4:0]  rd_idx;
      logic [31:0] wdata;
      logic        ldm;
      logic        stm;
      logic        berr;
   } exp_t;

   logic        clk, rst;
   logic        MEM_valid_i, lsu_ready_o, MEM_rd_wen_i;
   logic [31:0] MEM_pc_i, MEM_alu_res_i, MEM_rs2_rdata_i;
   logic [4:0]  MEM_ld_st_info_i, MEM_rd_idx_i;
   logic        dbus_req_o, dbus_we_o, dbus_gnt_i, dbus_rvalid_i, dbus_err_i;
   logic [31:0] dbus_addr_o, dbus_wdata_o, dbus_rdata_i;
   logic [3:0]  dbus_be_o;
   logic        WB_ready_i, LSU_valid_o, LSU_rd_wen_o;
   logic        LSU_ld_misalign_o, LSU_st_misalign_o, LSU_bus_err_o;
   logic [31:0] LSU_pc_o, LSU_rd_wdata_o;
   logic [4:0]  LSU_rd_idx_o;

   int   n_pass  = 0;
   int   n_total = 0;
   int   n_beats = 0;
   exp_t exp_q[$];

   mem_lsu dut (
      .clk               (clk),
      .rst               (rst),
      .MEM_valid_i       (MEM_valid_i),
      .lsu_ready_o       (lsu_ready_o),
      .MEM_pc_i          (MEM_pc_i),
      .MEM_ld_st_info_i  (MEM_ld_st_info_i),
      .MEM_rd_wen_i      (MEM_rd_wen_i),
      .MEM_rd_idx_i      (MEM_rd_idx_i),
      .MEM_alu_res_i     (MEM_alu_res_i),
      .MEM_rs2_rdata_i   (MEM_rs2_rdata_i),
      .dbus_req_o        (dbus_req_o),
      .dbus_we_o         (dbus_we_o),
      .dbus_addr_o       (dbus_addr_o),
      .dbus_be_o         (dbus_be_o),
      .dbus_wdata_o      (dbus_wdata_o),
      .dbus_gnt_i        (dbus_gnt_i),
      .dbus_rvalid_i     (dbus_rvalid_i),
      .dbus_rdata_i      (dbus_rdata_i),
      .dbus_err_i        (dbus_err_i),
      .WB_ready_i        (WB_ready_i),
      .LSU_valid_o       (LSU_valid_o),
      .LSU_pc_o          (LSU_pc_o),
      .LSU_rd_wen_o      (LSU_rd_wen_o),
      .LSU_rd_idx_o      (LSU_rd_idx_o),
      .LSU_rd_wdata_o    (LSU_rd_wdata_o),
      .LSU_ld_misalign_o (LSU_ld_misalign_o),
      .LSU_st_misalign_o (LSU_st_misalign_o),
      .LSU_bus_err_o     (LSU_bus_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got %0d/%0d checks passed so far", n_pass, n_total);
      $fatal(1, "timeout");
   end

   function automatic exp_t mk_exp(logic [31:0] pc, logic wen, logic [4:0] rd, logic [31:0] wd,
                                   logic ldm, logic stm, logic berr);
      exp_t e;
      e.pc = pc; e.rd_wen = wen; e.rd_idx = rd; e.wdata = wd;
      e.ldm = ldm; e.stm = stm; e.berr = berr;
      return e;
   endfunction

   // Reference load extraction by lane selection.
   function automatic logic [31:0] ref_load(logic [31:0] w, logic [1:0] a, logic [1:0] sz, logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[8*a +: 8];
      h = a[1] ? w[31:16] : w[15:0];
      case (sz)
         2'd0:    return uns ? {24'h0, b} : {{24{b[7]}}, b};
         2'd1:    return uns ? {16'h0, h} : {{16{h[15]}}, h};
         default: return w;
      endcase
   endfunction

   // Scoreboard monitor: one comparison per WB handshake.
   always begin
      exp_t e, obs;
      @(negedge clk);
      #2;
      if (!rst && LSU_valid_o && WB_ready_i) begin
         n_beats++;
         n_total++;
         obs = mk_exp(LSU_pc_o, LSU_rd_wen_o, LSU_rd_idx_o, LSU_rd_wdata_o,
                      LSU_ld_misalign_o, LSU_st_misalign_o, LSU_bus_err_o);
         if (exp_q.size() == 0) begin
            $display("FAIL beat_unexpected: got entry %h, expected no beat", obs);
         end else begin
            e = exp_q.pop_front();
            if (obs !== e)
               $display("FAIL wb_entry: got pc=%h wen=%b rd=%0d wd=%h ldm=%b stm=%b berr=%b, expected pc=%h wen=%b rd=%0d wd=%h ldm=%b stm=%b berr=%b",
                        obs.pc, obs.rd_wen, obs.rd_idx, obs.wdata, obs.ldm, obs.stm, obs.berr,
                        e.pc, e.rd_wen, e.rd_idx, e.wdata, e.ldm, e.stm, e.berr);
            else
               n_pass++;
         end
      end
   end

   task automatic drive_entry(logic [31:0] pc, logic [4:0] info, logic wen, logic [4:0] rd,
                              logic [31:0] res, logic [31:0] rs2);
      MEM_valid_i = 1'b1; MEM_pc_i = pc; MEM_ld_st_info_i = info; MEM_rd_wen_i = wen;
      MEM_rd_idx_i = rd; MEM_alu_res_i = res; MEM_rs2_rdata_i = rs2;
   endtask

   // Drives one memory entry, acts as the bus slave and reports what was seen
   // on the bus. Entered and left at a negedge drive point with the DUT idle.
   task automatic mem_access(input logic [31:0] pc, input logic [4:0] info, input logic wen,
                             input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] rs2,
                             input int gnt_delay, input logic [31:0] rdata, input logic err,
                             output int req_cycles, output logic [3:0] be, output logic [31:0] da,
                             output logic [31:0] wd, output logic we, output logic stable,
                             output logic ready_low);
      int waited;
      @(negedge clk);
      drive_entry(pc, info, wen, rd, addr, rs2);
      @(negedge clk);
      MEM_valid_i = 1'b0; MEM_alu_res_i = ~addr; MEM_rs2_rdata_i = ~rs2; MEM_ld_st_info_i = ~info;
      #1;
      req_cycles = 0; waited = 0; stable = 1'b1; ready_low = 1'b1;
      be = '0; da = '0; wd = '0; we = 1'b0;
      while (dbus_req_o && req_cycles < 50) begin
         if (req_cycles == 0) begin
            be = dbus_be_o; da = dbus_addr_o; wd = dbus_wdata_o; we = dbus_we_o;
         end else if ({be, da, wd, we} !== {dbus_be_o, dbus_addr_o, dbus_wdata_o, dbus_we_o}) begin
            stable = 1'b0;
         end
         if (lsu_ready_o !== 1'b0) ready_low = 1'b0;
         req_cycles++;
         if (waited == gnt_delay) dbus_gnt_i = 1'b1;
         waited++;
         @(negedge clk);
         dbus_gnt_i = 1'b0;
         #1;
      end
      if (req_cycles >= 50) begin
         n_total++;
         $display("FAIL req_bound: dbus_req_o still high after %0d cycles, expected grant accepted", req_cycles);
      end
      if (req_cycles > 0) begin
         if (lsu_ready_o !== 1'b0) ready_low = 1'b0;
         dbus_rvalid_i = 1'b1; dbus_rdata_i = rdata; dbus_err_i = err;
         @(negedge clk);
         dbus_rvalid_i = 1'b0; dbus_err_i = 1'b0; dbus_rdata_i = 32'h0;
      end
      @(negedge clk);
      MEM_ld_st_info_i = 5'd0;
   endtask

   task automatic test_reset();
      rst = 1'b1; MEM_valid_i = 1'b0; MEM_pc_i = 0; MEM_ld_st_info_i = 0; MEM_rd_wen_i = 0;
      MEM_rd_idx_i = 0; MEM_alu_res_i = 0; MEM_rs2_rdata_i = 0; dbus_gnt_i = 0;
      dbus_rvalid_i = 0; dbus_rdata_i = 0; dbus_err_i = 0; WB_ready_i = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      n_total++;
      if ({dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o, lsu_ready_o} !== 71'd0)
         $display("FAIL reset_bus: got req=%b we=%b addr=%h be=%b wdata=%h ready=%b, expected all 0",
                  dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o, lsu_ready_o);
      else n_pass++;
      n_total++;
      if ({LSU_valid_o, LSU_pc_o, LSU_rd_wen_o, LSU_rd_idx_o, LSU_rd_wdata_o,
           LSU_ld_misalign_o, LSU_st_misalign_o, LSU_bus_err_o} !== 74'd0)
         $display("FAIL reset_wb: got valid=%b pc=%h wdata=%h, expected all 0",
                  LSU_valid_o, LSU_pc_o, LSU_rd_wdata_o);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_total++;
      if (lsu_ready_o !== 1'b1) $display("FAIL idle_ready: got %b, expected 1", lsu_ready_o);
      else n_pass++;
   endtask

   task automatic test_alu_stream();
      WB_ready_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         drive_entry(32'h100 + 32'(4 * k), 5'd0, 1'b1, 5'd5, 32'h1234, 32'h0);
         exp_q.push_back(mk_exp(32'h100 + 32'(4 * k), 1'b1, 5'd5, 32'h1234, 1'b0, 1'b0, 1'b0));
         #1;
         n_total++;
         if (lsu_ready_o !== 1'b1) $display("FAIL alu_no_stall: cycle %0d ready=%b, expected 1", k, lsu_ready_o);
         else n_pass++;
         if (k > 0) begin
            n_total++;
            if (LSU_valid_o !== 1'b1) $display("FAIL alu_back_to_back: cycle %0d valid=%b, expected 1", k, LSU_valid_o);
            else n_pass++;
         end
      end
      @(negedge clk);
      MEM_valid_i = 1'b0;
      #1;
      n_total++;
      if (LSU_valid_o !== 1'b1) $display("FAIL alu_third_beat: valid=%b, expected 1", LSU_valid_o);
      else n_pass++;
      @(negedge clk);
      #1;
      n_total++;
      if ({LSU_valid_o, LSU_pc_o, LSU_rd_wdata_o} !== 65'd0)
         $display("FAIL idle_masked: got valid=%b pc=%h wdata=%h, expected 0", LSU_valid_o, LSU_pc_o, LSU_rd_wdata_o);
      else n_pass++;
   endtask

   task automatic test_load();
      int rc; logic [3:0] be; logic [31:0] da, wd; logic we, st, rl;
      logic [31:0] addr_t [3] = '{32'h1002, 32'h1000, 32'h1000};
      logic [4:0]  info_t [3] = '{5'b10001, 5'b10101, 5'b10010};
      logic [31:0] word_t [3] = '{32'h8001_1234, 32'h8001_F234, 32'hCAFE_F00D};
      WB_ready_i = 1'b1;
      exp_q.push_back(mk_exp(32'h200, 1'b1, 5'd10, 32'hFFFF_FF80, 1'b0, 1'b0, 1'b0));
      mem_access(32'h200, 5'b10000, 1'b1, 5'd10, 32'h1003, 32'h0, 0, 32'h80FF_FFFF, 1'b0,
                 rc, be, da, wd, we, st, rl);
      n_total++;
      if ({rc == 1, be, da, we} !== {1'b1, 4'b1000, 32'h1000, 1'b0})
         $display("FAIL lb_bus: got req_cycles=%0d be=%b addr=%h we=%b, expected 1 1000 00001000 0", rc, be, da, we);
      else n_pass++;
      exp_q.push_back(mk_exp(32'h204, 1'b1, 5'd10, 32'h0000_0080, 1'b0, 1'b0, 1'b0));
      mem_access(32'h204, 5'b10100, 1'b1, 5'd10, 32'h1003, 32'h0, 0, 32'h80FF_FFFF, 1'b0,
                 rc, be, da, wd, we, st, rl);
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(mk_exp(32'h300 + 32'(4 * i), 1'b1, 5'd12,
                                ref_load(word_t[i], addr_t[i][1:0], info_t[i][1:0], info_t[i][2]),
                                1'b0, 1'b0, 1'b0));
         mem_access(32'h300 + 32'(4 * i), info_t[i], 1'b1, 5'd12, addr_t[i], 32'h0, 0, word_t[i], 1'b0,
                    rc, be, da, wd, we, st, rl);
      end
   endtask

   task automatic test_store();
      int rc; logic [3:0] be; logic [31:0] da, wd; logic we, st, rl;
      WB_ready_i = 1'b1;
      exp_q.push_back(mk_exp(32'h500, 1'b0, 5'd0, 32'h2002, 1'b0, 1'b0, 1'b0));
      mem_access(32'h500, 5'b01001, 1'b0, 5'd0, 32'h2002, 32'hABCD_1234, 0, 32'h0, 1'b0,
                 rc, be, da, wd, we, st, rl);
      n_total++;
      if ({da, be, wd, we} !== {32'h2000, 4'b1100, 32'h1234_1234, 1'b1})
         $display("FAIL sh_bus: got addr=%h be=%b wdata=%h we=%b, expected 00002000 1100 12341234 1", da, be, wd, we);
      else n_pass++;
      exp_q.push_back(mk_exp(32'h504, 1'b0, 5'd0, 32'h2001, 1'b0, 1'b0, 1'b0));
      mem_access(32'h504, 5'b01000, 1'b0, 5'd0, 32'h2001, 32'h0000_00EF, 0, 32'h0, 1'b0,
                 rc, be, da, wd, we, st, rl);
      n_total++;
      if ({be, wd} !== {4'b0010, 32'hEFEF_EFEF})
         $display("FAIL sb_bus: got be=%b wdata=%h, expected 0010 efefefef", be, wd);
      else n_pass++;
      exp_q.push_back(mk_exp(32'h508, 1'b0, 5'd0, 32'h2004, 1'b0, 1'b0, 1'b0));
      mem_access(32'h508, 5'b01010, 1'b0, 5'd0, 32'h2004, 32'h1357_9BDF, 0, 32'h0, 1'b0,
                 rc, be, da, wd, we, st, rl);
      n_total++;
      if ({da, be, wd} !== {32'h2004, 4'b1111, 32'h1357_9BDF})
         $display("FAIL sw_bus: got addr=%h be=%b wdata=%h, expected 00002004 1111 13579bdf", da, be, wd);
      else n_pass++;
   endtask

   task automatic test_misalign();
      WB_ready_i = 1'b1;
      @(negedge clk);
      drive_entry(32'h400, 5'b10010, 1'b1, 5'd11, 32'h3001, 32'h0);
      exp_q.push_back(mk_exp(32'h400, 1'b0, 5'd11, 32'h3001, 1'b1, 1'b0, 1'b0));
      @(negedge clk);
      MEM_valid_i = 1'b0;
      #1;
      n_total++;
      if ({dbus_req_o, LSU_valid_o, LSU_ld_misalign_o, LSU_rd_wen_o} !== 4'b0110)
         $display("FAIL lw_misalign: got req=%b valid=%b ldm=%b wen=%b, expected 0 1 1 0",
                  dbus_req_o, LSU_valid_o, LSU_ld_misalign_o, LSU_rd_wen_o);
      else n_pass++;
      @(negedge clk);
      drive_entry(32'h404, 5'b01001, 1'b0, 5'd0, 32'h2003, 32'h5555_AAAA);
      exp_q.push_back(mk_exp(32'h404, 1'b0, 5'd0, 32'h2003, 1'b0, 1'b1, 1'b0));
      @(negedge clk);
      MEM_valid_i = 1'b0;
      #1;
      n_total++;
      if ({dbus_req_o, LSU_valid_o, LSU_st_misalign_o} !== 3'b011)
         $display("FAIL sh_misalign: got req=%b valid=%b stm=%b, expected 0 1 1",
                  dbus_req_o, LSU_valid_o, LSU_st_misalign_o);
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_bus_err();
      int rc; logic [3:0] be; logic [31:0] da, wd; logic we, st, rl;
      WB_ready_i = 1'b1;
      exp_q.push_back(mk_exp(32'h700, 1'b0, 5'd9, 32'h0, 1'b0, 1'b0, 1'b1));
      mem_access(32'h700, 5'b10010, 1'b1, 5'd9, 32'h3000, 32'h0, 3, 32'hDEAD_BEEF, 1'b1,
                 rc, be, da, wd, we, st, rl);
      n_total++;
      if ({rc == 4, st, rl, da, be} !== {1'b1, 1'b1, 1'b1, 32'h3000, 4'b1111})
         $display("FAIL gnt_delay: got req_cycles=%0d stable=%b ready_low=%b addr=%h be=%b, expected 4 1 1 00003000 1111",
                  rc, st, rl, da, be);
      else n_pass++;
   endtask

   task automatic test_wb_stall();
      @(negedge clk);
      WB_ready_i = 1'b0;
      drive_entry(32'h600, 5'd0, 1'b1, 5'd7, 32'hA5A5, 32'h0);
      exp_q.push_back(mk_exp(32'h600, 1'b1, 5'd7, 32'hA5A5, 1'b0, 1'b0, 1'b0));
      @(negedge clk);
      drive_entry(32'h604, 5'd0, 1'b1, 5'd8, 32'h5A5A, 32'h0);
      for (int i = 0; i < 5; i++) begin
         #1;
         n_total++;
         if ({LSU_valid_o, LSU_pc_o, LSU_rd_wdata_o, LSU_rd_idx_o, lsu_ready_o} !==
             {1'b1, 32'h600, 32'hA5A5, 5'd7, 1'b0})
            $display("FAIL stall_hold: cycle %0d got valid=%b pc=%h wd=%h rd=%0d ready=%b, expected 1 600 a5a5 7 0",
                     i, LSU_valid_o, LSU_pc_o, LSU_rd_wdata_o, LSU_rd_idx_o, lsu_ready_o);
         else n_pass++;
         @(negedge clk);
      end
      WB_ready_i = 1'b1;
      exp_q.push_back(mk_exp(32'h604, 1'b1, 5'd8, 32'h5A5A, 1'b0, 1'b0, 1'b0));
      #1;
      n_total++;
      if (lsu_ready_o !== 1'b1) $display("FAIL stall_release: ready=%b, expected 1", lsu_ready_o);
      else n_pass++;
      @(negedge clk);
      MEM_valid_i = 1'b0;
      #1;
      n_total++;
      if (LSU_pc_o !== 32'h604) $display("FAIL stall_next: pc=%h, expected 00000604", LSU_pc_o);
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_access();
      int beats0;
      WB_ready_i = 1'b1;
      beats0 = n_beats;
      @(negedge clk);
      drive_entry(32'h800, 5'b10010, 1'b1, 5'd3, 32'h4000, 32'h0);
      @(negedge clk);
      MEM_valid_i = 1'b0;
      #1;
      n_total++;
      if (dbus_req_o !== 1'b1) $display("FAIL rst_pre_req: req=%b, expected 1", dbus_req_o);
      else n_pass++;
      dbus_gnt_i = 1'b1;
      @(negedge clk);
      dbus_gnt_i = 1'b0;
      #1;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_total++;
      if ({dbus_req_o, LSU_valid_o, lsu_ready_o} !== 3'b001)
         $display("FAIL rst_wait: got req=%b valid=%b ready=%b, expected 0 0 1", dbus_req_o, LSU_valid_o, lsu_ready_o);
      else n_pass++;
      dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'h1111_2222;
      @(negedge clk);
      dbus_rvalid_i = 1'b0; dbus_rdata_i = 32'h0;
      #1;
      n_total++;
      if (LSU_valid_o !== 1'b0) $display("FAIL late_rvalid: valid=%b, expected 0", LSU_valid_o);
      else n_pass++;
      repeat (3) @(negedge clk);
      #3;
      n_total++;
      if (n_beats != beats0) $display("FAIL rst_no_beat: got %0d beats, expected %0d", n_beats, beats0);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_alu_stream();
      test_load();
      test_store();
      test_misalign();
      test_bus_err();
      test_wb_stall();
      test_reset_mid_access();
      repeat (3) @(negedge clk);
      #3;
      n_total++;
      if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
